// File: rtl/corr_block_sched.sv
// Block scheduler for the time-multiplexed correlator: sample tick phase, first-sample clear,
// bank switching at block end and tracking of filled banks awaiting host readback.
module corr_block_sched #(
  parameter int unsigned ACCUM = 24,
  parameter int unsigned TICKS = 4,
  parameter int unsigned BANKS = 16,
  parameter int unsigned BSB   = 4,
  parameter int unsigned TBITS = 2
) (
  input  logic             clk_x,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [ACCUM-1:0] size_i,
  output logic             go_o,
  output logic [TBITS-1:0] tick_o,
  output logic             clr_o,
  output logic             sw_o,
  output logic [BSB-1:0]   bank_o,
  output logic             avail_o,
  output logic [BSB-1:0]   rd_bank_o,
  input  logic             rd_ack_i,
  output logic             overflow_o
);

  typedef enum logic [1:0] {StIdle, StRun, StStall} state_e;

  localparam logic [TBITS-1:0] TickLast = TBITS'(TICKS - 1);
  localparam logic [BSB:0]     FillFull = (BSB + 1)'(BANKS);

  state_e           r_state;
  logic [ACCUM-1:0] r_size;
  logic [ACCUM-1:0] r_sample;
  logic [BSB:0]     r_fill;
  logic             r_go;
  logic [TBITS-1:0] r_tick;
  logic             r_clr;
  logic             r_sw;
  logic [BSB-1:0]   r_bank;
  logic             r_avail;
  logic [BSB-1:0]   r_rd_bank;
  logic             r_ovf;

  logic         w_tick_last;
  logic         w_blk_end;
  logic         w_ack;
  logic [BSB:0] w_fill_nxt;
  logic         w_full;

  assign w_tick_last = (r_tick == TickLast);
  assign w_blk_end   = (r_state == StRun) && w_tick_last && (r_sample == r_size);
  assign w_ack       = rd_ack_i && (r_fill != '0);
  // An ack on the switching edge cancels the new fill, so the stall test sees the net count.
  assign w_fill_nxt  = r_fill + (BSB + 1)'(w_blk_end) - (BSB + 1)'(w_ack);
  assign w_full      = (w_fill_nxt == FillFull);

  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_size    <= '0;
      r_sample  <= '0;
      r_fill    <= '0;
      r_go      <= 1'b0;
      r_tick    <= '0;
      r_clr     <= 1'b0;
      r_sw      <= 1'b0;
      r_bank    <= '0;
      r_avail   <= 1'b0;
      r_rd_bank <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_sw    <= 1'b0;
      r_fill  <= w_fill_nxt;
      r_avail <= (w_fill_nxt != '0);
      if (w_ack) begin
        r_rd_bank <= r_rd_bank + 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (en_i) begin
            r_state  <= StRun;
            r_size   <= size_i;
            r_sample <= '0;
            r_tick   <= '0;
            r_ovf    <= 1'b0;
            r_go     <= 1'b1;
            r_clr    <= 1'b1;
          end
        end
        StRun: begin
          if (w_blk_end) begin
            r_sw     <= 1'b1;
            r_bank   <= r_bank + 1'b1;
            r_sample <= '0;
            r_size   <= size_i;
            r_tick   <= '0;
            if (w_full) begin
              r_state <= StStall;
              r_ovf   <= 1'b1;
              r_go    <= 1'b0;
              r_clr   <= 1'b0;
            end else if (!en_i) begin
              r_state <= StIdle;
              r_go    <= 1'b0;
              r_clr   <= 1'b0;
            end else begin
              r_clr <= 1'b1;
            end
          end else if (w_tick_last) begin
            r_tick   <= '0;
            r_sample <= r_sample + 1'b1;
            r_clr    <= 1'b0;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        StStall: begin
          if (w_ack) begin
            if (en_i) begin
              r_state  <= StRun;
              r_size   <= size_i;
              r_sample <= '0;
              r_tick   <= '0;
              r_go     <= 1'b1;
              r_clr    <= 1'b1;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign go_o       = r_go;
  assign tick_o     = r_tick;
  assign clr_o      = r_clr;
  assign sw_o       = r_sw;
  assign bank_o     = r_bank;
  assign avail_o    = r_avail;
  assign rd_bank_o  = r_rd_bank;
  assign overflow_o = r_ovf;

endmodule

// File: doc/corr_block_sched.md
Name: corr_block_sched

Overview:
- Sequences the time-multiplexed correlator datapath.
- Generates the per-sample tick phase and the first-sample clear.
- At the end of each accumulation block it issues the bank-switch pulse and advances the write bank.
- Tracks filled banks awaiting host readback, stalling the correlator and flagging overflow when all banks are unread.

Parameters:
ACCUM, 24, width of block-size register/sample counter
TICKS, 4, clk_x cycles per antenna sample (correlator time-multiplex factor), >=1
BANKS, 16, number of visibility banks, power of two >=2
BSB, 4, log2(BANKS)
TBITS, 2, max(1, clog2(TICKS))

Ports:
clk_x  in  1  correlator clock
rst_n  in  1  asynchronous, active-low reset
en_i  in  1  run enable (level)
size_i  in  ACCUM  samples per block minus 1; latched at block start
go_o  out  1  correlator datapath enable
tick_o  out  TBITS  phase within current sample, 0..TICKS-1
clr_o  out  1  high for all TICKS cycles of the first sample of a block (load, not add)
sw_o  out  1  one-cycle bank-switch pulse
bank_o  out  BSB  current write bank
avail_o  out  1  at least one filled bank awaiting readback
rd_bank_o  out  BSB  oldest filled bank
rd_ack_i  in  1  one-cycle pulse: host finished reading rd_bank_o
overflow_o  out  1  sticky: scheduler stalled because all banks were unread

Behaviour:
- Reset: state IDLE; all outputs 0; internal tick, sample, bank, rd_bank and fill counters 0. Reset is asynchronous, active-low; deassertion is synchronous to clk_x.
- All outputs are registered.
- IDLE:
  - go_o=0, tick_o=0.
  - en_i=1 sampled at edge k: latch size_i, clear overflow_o, enter RUN.
  - From cycle k+1: go_o=1, clr_o=1, tick_o=0.
- RUN:
  - tick_o increments each cycle, wrapping TICKS-1 -> 0.
  - At tick_o==TICKS-1 the sample counter increments.
  - clr_o=1 only while sample counter==0.
  - Block end: tick_o==TICKS-1 and sample counter==latched size.
  - Next cycle at block end: sw_o=1 for one cycle; bank_o <= bank_o+1 mod BANKS; fill count +1; sample counter 0; size_i re-latched.
  - size_i changes mid-block have no effect until the next block.
  - size_i=0: every sample is a full block; sw_o pulses every TICKS cycles and clr_o stays high.
- Block-end decisions (evaluated on the cycle sw_o is asserted):
  - New fill count == BANKS: enter STALL, set overflow_o, go_o=0. bank_o then equals rd_bank_o and is not written.
  - Else en_i==0: enter IDLE, go_o=0.
  - Else: continue RUN with clr_o=1, tick_o=0.
  - en_i is only sampled at block boundaries; partial blocks are never produced or switched.
- STALL:
  - go_o=0, clr_o=0, tick_o=0.
  - First accepted rd_ack_i: rd_bank advances and fill count becomes BANKS-1.
  - Then re-enter RUN (if en_i=1) or IDLE (if en_i=0) the next cycle, starting a fresh block with clr_o=1.
  - overflow_o stays set until reset or the next IDLE->RUN start.
- Readback:
  - avail_o = (fill count != 0).
  - rd_ack_i with fill count 0 is ignored.
  - Accepted ack: rd_bank_o <= rd_bank_o+1 mod BANKS; fill count -1.
  - Ack on the same cycle as sw_o: fill count unchanged; both pointers advance. The stall check uses this net count.
- Fill count is 0..BANKS, BSB+1 bits. Pointers wrap mod BANKS naturally.
- Reset mid-block or in STALL: immediate return to reset state. No sw_o pulse; no partial-block accounting.

Test Plan:
- TICKS=4, BANKS=4, size_i=2, en_i held 1, host acks each sw_o within 2 cycles:
  - sw_o pulses every 12 cycles.
  - bank_o steps 0,1,2,3,0.
  - clr_o high for cycles 0..3 of each block.
  - tick_o cycles 0,1,2,3.
  - avail_o pulses; overflow_o stays 0.
- Same config, no acks:
  - After 3 switches, avail_o=1 with rd_bank_o=0 and fill 3.
  - 4th switch: STALL, go_o=0, overflow_o=1, bank_o=0.
  - One rd_ack_i: RUN resumes next cycle writing bank 0, rd_bank_o=1, clr_o=1.
- size_i=0, TICKS=4: sw_o every 4 cycles; clr_o constantly 1 while running.
- en_i dropped mid-block at sample 1: block completes; sw_o fires; IDLE follows; go_o=0 with no further sw_o.
- rd_ack_i coincident with sw_o at fill count 3 (BANKS=4): fill stays 3; no stall; both pointers advance.
- Extra cases:
  - Spurious rd_ack_i at fill 0: no change.
  - rst_n pulsed low mid-block: all outputs 0 asynchronously; bank_o=0.
  - Restart via en_i: fresh block from bank 0; overflow_o cleared.
